// File: rtl/pixel_checker_pkg.sv
// Shared types and CRC constants for the pixel stream self-checker.
package pixel_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_DONE
    } checker_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

endpackage

// File: rtl/pixel_crc16.sv
// One-cycle CRC-16-CCITT step over BYTES bytes, most significant byte first.
module pixel_crc16
    import pixel_checker_pkg::*;
#(
    parameter int BYTES = 3
) (
    input  logic [15:0]        crc_in,
    input  logic [8*BYTES-1:0] data,
    output logic [15:0]        crc_out
);

    logic [15:0] crc_work;

    always_comb begin
        crc_work = crc_in;
        for (int b = BYTES - 1; b >= 0; b--) begin
            crc_work = crc_work ^ {data[8*b +: 8], 8'h00};
            for (int i = 0; i < 8; i++) begin
                if (crc_work[15])
                    crc_work = {crc_work[14:0], 1'b0} ^ CRC16_POLY;
                else
                    crc_work = {crc_work[14:0], 1'b0};
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/pixel_stream_checker.sv
// Compares the active-window pixel stream against an expected stream and keeps error status.
// Define PIXEL_CRC_EN to build the CRC-16 over the observed stream; otherwise frame_crc is 0.
//
//  state   | meaning
//  S_IDLE  | after reset, waiting for start
//  S_ARMED | waiting for frame_sync
//  S_CHECK | comparing active-window pixels
//  S_DONE  | results frozen, start re-arms
module pixel_stream_checker
    import pixel_checker_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int CH_WIDTH       = 8,
    parameter int H_ACTIVE       = 320,
    parameter int V_ACTIVE       = 240,
    parameter int CNT_WIDTH      = 20,
    parameter int MAX_MISMATCHES = 10,
    localparam int PIX_W = CHANNELS * CH_WIDTH,
    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 frame_sync,
    input  logic                 pixel_valid,
    input  logic [PIX_W-1:0]     pixel_data,
    input  logic                 exp_valid,
    input  logic [PIX_W-1:0]     exp_data,
    output logic                 exp_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 aborted,
    output logic                 underrun,
    output logic                 truncated,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic [COL_W-1:0]     first_err_col,
    output logic [ROW_W-1:0]     first_err_row,
    output logic [CHANNELS-1:0]  first_err_mask,
    output logic [15:0]          frame_crc
);

    checker_state_t       state;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic                 last_pix;
    logic                 accept;
    logic                 start_ok;
    logic                 abort_hit;
    logic [CHANNELS-1:0]  mask;
    logic [CNT_WIDTH:0]   count_sum;
    logic [CNT_WIDTH-1:0] count_next;

    assign last_pix  = (col == COL_W'(H_ACTIVE - 1)) && (row == ROW_W'(V_ACTIVE - 1));
    // A frame_sync that lands on the final pixel still lets that pixel complete the frame.
    assign accept    = (state == S_CHECK) && pixel_valid && (!frame_sync || last_pix);
    assign exp_ready = accept && exp_valid;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        mask      = '0;
        count_sum = {1'b0, mismatch_count};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            mask[ch]  = exp_valid &&
                        (pixel_data[PIX_W-1-ch*CH_WIDTH -: CH_WIDTH] !=
                         exp_data[PIX_W-1-ch*CH_WIDTH -: CH_WIDTH]);
            count_sum = count_sum + {{CNT_WIDTH{1'b0}}, mask[ch]};
        end
        count_next = count_sum[CNT_WIDTH] ? '1 : count_sum[CNT_WIDTH-1:0];
        abort_hit  = (MAX_MISMATCHES != 0) && (count_next >= CNT_WIDTH'(MAX_MISMATCHES));
    end

    assign busy = (state == S_ARMED) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (mismatch_count == '0) && !underrun && !truncated && !aborted;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            col            <= '0;
            row            <= '0;
            aborted        <= 1'b0;
            underrun       <= 1'b0;
            truncated      <= 1'b0;
            mismatch_count <= '0;
            first_err_col  <= '0;
            first_err_row  <= '0;
            first_err_mask <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state          <= S_ARMED;
                        col            <= '0;
                        row            <= '0;
                        aborted        <= 1'b0;
                        underrun       <= 1'b0;
                        truncated      <= 1'b0;
                        mismatch_count <= '0;
                        first_err_col  <= '0;
                        first_err_row  <= '0;
                        first_err_mask <= '0;
                    end
                end
                S_ARMED: begin
                    if (frame_sync) begin
                        state <= S_CHECK;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (col == COL_W'(H_ACTIVE - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        mismatch_count <= count_next;
                        if (!exp_valid)
                            underrun <= 1'b1;
                        // A non-zero count means the first error is already recorded.
                        if ((mask != '0) && (mismatch_count == '0)) begin
                            first_err_col  <= col;
                            first_err_row  <= row;
                            first_err_mask <= mask;
                        end
                        if (abort_hit)
                            aborted <= 1'b1;
                        if (last_pix || abort_hit)
                            state <= S_DONE;
                    end else if (frame_sync) begin
                        truncated <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PIXEL_CRC_EN
    logic [15:0] crc_step;

    pixel_crc16 #(
        .BYTES(CHANNELS)
    ) u_crc (
        .crc_in (frame_crc),
        .data   (pixel_data),
        .crc_out(crc_step)
    );

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset)
            frame_crc <= '0;
        else if (start_ok)
            frame_crc <= CRC16_SEED;
        else if (accept)
            frame_crc <= crc_step;
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_stream_checker.sv
// Directed self-checking bench for pixel_stream_checker on a 4x2 window.
module tb_pixel_stream_checker;

    localparam int CH = 3;
    localparam int CW = 8;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NW = 20;

    logic        clock_50 = 1'b0;
    logic        reset;
    logic        start;
    logic        frame_sync;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        exp_valid;
    logic [23:0] exp_data;

    logic          exp_ready, busy, done, pass, aborted, underrun, truncated;
    logic [NW-1:0] mismatch_count;
    logic [1:0]    first_err_col;
    logic [0:0]    first_err_row;
    logic [2:0]    first_err_mask;
    logic [15:0]   frame_crc;

    logic          ab_exp_ready, ab_busy, ab_done, ab_pass, ab_aborted, ab_underrun, ab_truncated;
    logic [NW-1:0] ab_mismatch_count;
    logic [1:0]    ab_first_err_col;
    logic [0:0]    ab_first_err_row;
    logic [2:0]    ab_first_err_mask;
    logic [15:0]   ab_frame_crc;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] crc_exp;

    always #10 clock_50 = ~clock_50;

    pixel_stream_checker #(
        .CHANNELS(CH), .CH_WIDTH(CW), .H_ACTIVE(H), .V_ACTIVE(V),
        .CNT_WIDTH(NW), .MAX_MISMATCHES(0)
    ) dut (
        .clock_50(clock_50), .reset(reset), .start(start), .frame_sync(frame_sync),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .busy(busy), .done(done), .pass(pass), .aborted(aborted),
        .underrun(underrun), .truncated(truncated), .mismatch_count(mismatch_count),
        .first_err_col(first_err_col), .first_err_row(first_err_row),
        .first_err_mask(first_err_mask), .frame_crc(frame_crc)
    );

    pixel_stream_checker #(
        .CHANNELS(CH), .CH_WIDTH(CW), .H_ACTIVE(H), .V_ACTIVE(V),
        .CNT_WIDTH(NW), .MAX_MISMATCHES(2)
    ) dut_ab (
        .clock_50(clock_50), .reset(reset), .start(start), .frame_sync(frame_sync),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(ab_exp_ready),
        .busy(ab_busy), .done(ab_done), .pass(ab_pass), .aborted(ab_aborted),
        .underrun(ab_underrun), .truncated(ab_truncated), .mismatch_count(ab_mismatch_count),
        .first_err_col(ab_first_err_col), .first_err_row(ab_first_err_row),
        .first_err_mask(ab_first_err_mask), .frame_crc(ab_frame_crc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] pix(input int i);
        return 24'h102030 + 24'(i) * 24'h030507;
    endfunction

    // Bit-serial reference CRC-16-CCITT, bytes taken MSB first.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int k = 23; k >= 0; k--) begin
            if (r[15] ^ d[k]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        frame_sync  = 1'b0;
        pixel_valid = 1'b0;
        exp_valid   = 1'b0;
        pixel_data  = '0;
        exp_data    = '0;
    endtask

    // Start pulse, a stray pixel while armed, then frame_sync carrying its own ignored pixel.
    task automatic arm();
        start = 1'b1;
        tick();
        start       = 1'b0;
        pixel_valid = 1'b1;
        exp_valid   = 1'b1;
        pixel_data  = 24'hABCDEF;
        exp_data    = 24'h000000;
        tick();
        frame_sync = 1'b1;
        #1;
        chk("exp_ready_sync_cycle", exp_ready, 0);
        tick();
        idle_inputs();
        crc_exp = 16'hFFFF;
    endtask

    task automatic send_pixel(input logic [23:0] pd, input logic [23:0] ed, input logic ev);
        pixel_valid = 1'b1;
        pixel_data  = pd;
        exp_data    = ed;
        exp_valid   = ev;
        #1;
        chk("exp_ready", exp_ready, 32'(ev));
        crc_exp = crc_ref(crc_exp, pd);
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        crc_exp = 16'hFFFF;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_count", mismatch_count, 0);
        chk("rst_err_col", first_err_col, 0);
        chk("rst_crc", frame_crc, 0);
        reset = 1'b0;
        tick();
        chk("idle_done", done, 0);

        // Clean frame
        arm();
        chk("a_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            send_pixel(pix(i), pix(i), 1'b1);
            if (i == 6) chk("a_done_early", done, 0);
        end
        chk("a_done", done, 1);
        chk("a_pass", pass, 1);
        chk("a_count", mismatch_count, 0);
        chk("a_busy_end", busy, 0);
`ifdef PIXEL_CRC_EN
        chk("a_crc", frame_crc, crc_exp);
`else
        chk("a_crc_off", frame_crc, 0);
`endif

        // Pixel 5 has R and B wrong; start during the frame must be ignored
        arm();
        for (int i = 0; i < 8; i++) begin
            send_pixel(pix(i) ^ ((i == 5) ? 24'h010001 : 24'h0), pix(i), 1'b1);
            if (i == 5) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("b_start_ignored_cnt", mismatch_count, 2);
                chk("b_start_ignored_busy", busy, 1);
            end
        end
        chk("b_done", done, 1);
        chk("b_count", mismatch_count, 2);
        chk("b_col", first_err_col, 1);
        chk("b_row", first_err_row, 1);
        chk("b_mask", first_err_mask, 3'b101);
        chk("b_pass", pass, 0);

        // Abort at threshold 2 on dut_ab; dut keeps going and keeps its first error
        arm();
        send_pixel(pix(0) ^ 24'h000100, pix(0), 1'b1);
        chk("c_ab_done_p0", ab_done, 0);
        chk("c_ab_count_p0", ab_mismatch_count, 1);
        send_pixel(pix(1) ^ 24'h000001, pix(1), 1'b1);
        chk("c_ab_done", ab_done, 1);
        chk("c_ab_aborted", ab_aborted, 1);
        chk("c_ab_count", ab_mismatch_count, 2);
        chk("c_ab_mask", ab_first_err_mask, 3'b010);
        chk("c_busy", busy, 1);
        chk("c_aborted", aborted, 0);
        for (int i = 2; i < 8; i++)
            send_pixel(pix(i) ^ ((i == 4) ? 24'h800000 : 24'h0), pix(i), 1'b1);
        chk("c_ab_count_frozen", ab_mismatch_count, 2);
        chk("c_count", mismatch_count, 3);
        chk("c_col", first_err_col, 0);
        chk("c_row", first_err_row, 0);
        chk("c_mask_kept", first_err_mask, 3'b010);
        chk("c_done", done, 1);

        // Underrun on pixel 3 (its data also differs and must not be compared)
        arm();
        for (int i = 0; i < 8; i++) begin
            send_pixel(pix(i) ^ ((i == 3) ? 24'hFFFFFF : 24'h0), pix(i), i != 3);
            if (i == 6) chk("d_done_early", done, 0);
        end
        chk("d_done", done, 1);
        chk("d_underrun", underrun, 1);
        chk("d_count", mismatch_count, 0);
        chk("d_pass", pass, 0);
`ifdef PIXEL_CRC_EN
        chk("d_crc", frame_crc, crc_exp);
`endif

        // Truncation after 5 pixels, then a clean re-run
        arm();
        for (int i = 0; i < 5; i++)
            send_pixel(pix(i), pix(i), 1'b1);
        pixel_valid = 1'b1;
        exp_valid   = 1'b1;
        pixel_data  = pix(5) ^ 24'h00FF00;
        exp_data    = pix(5);
        frame_sync  = 1'b1;
        #1;
        chk("e_exp_ready_trunc", exp_ready, 0);
        tick();
        idle_inputs();
        chk("e_done", done, 1);
        chk("e_truncated", truncated, 1);
        chk("e_count", mismatch_count, 0);
        chk("e_pass", pass, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e_trunc_cleared", truncated, 0);
        chk("e_underrun_cleared", underrun, 0);
        chk("e_done_cleared", done, 0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        for (int i = 0; i < 8; i++)
            send_pixel(pix(i), pix(i), 1'b1);
        chk("e_rerun_pass", pass, 1);

        // Last pixel coincident with frame_sync: frame completes, no truncation
        arm();
        for (int i = 0; i < 7; i++)
            send_pixel(pix(i), pix(i), 1'b1);
        pixel_valid = 1'b1;
        exp_valid   = 1'b1;
        pixel_data  = pix(7);
        exp_data    = pix(7);
        frame_sync  = 1'b1;
        #1;
        chk("f_exp_ready_last", exp_ready, 1);
        tick();
        idle_inputs();
        chk("f_done", done, 1);
        chk("f_truncated", truncated, 0);
        chk("f_pass", pass, 1);

        // Reset mid-frame discards everything
        arm();
        for (int i = 0; i < 3; i++)
            send_pixel(pix(i) ^ ((i == 1) ? 24'h000010 : 24'h0), pix(i), 1'b1);
        chk("g_count_pre", mismatch_count, 1);
        reset = 1'b1;
        #2;
        chk("g_busy", busy, 0);
        chk("g_count", mismatch_count, 0);
        chk("g_mask", first_err_mask, 0);
        tick();
        reset = 1'b0;
        tick();
        arm();
        for (int i = 0; i < 8; i++)
            send_pixel(pix(i), pix(i), 1'b1);
        chk("g_rerun_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
